// File: rtl/r5fp_int_div_sqrt_mr.sv
// Iterative unsigned integer divide / square-root engine, R quotient/root bits per cycle.
// Restoring recurrence with abort, divide-by-zero flag and back-to-back issue.
module r5fp_int_div_sqrt_mr #(
  parameter int W = 26,
  parameter int R = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] N_i,
  input  logic [W-1:0] D_i,
  input  logic         is_div_i,
  input  logic         strobe_i,
  input  logic         kill_i,
  output logic [W-1:0] Quo_o,
  output logic [W-1:0] Rem_o,
  output logic         dz_o,
  output logic         done_o,
  output logic         ready_o
);

  localparam int ITER_DIV  = (W + R - 1) / R;
  localparam int HALF_W    = (W + 1) / 2;
  localparam int ITER_SQRT = (HALF_W + R - 1) / R;
  localparam int QW        = ITER_DIV * R;
  localparam int PW        = W + R + 1;
  localparam int DIV_NW    = ITER_DIV * R;
  localparam int SQ_NW     = 2 * ITER_SQRT * R;
  localparam int NSW       = (DIV_NW > SQ_NW) ? DIV_NW : SQ_NW;
  localparam int CW        = $clog2(ITER_DIV + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt_r;
  logic [NSW-1:0]  ns_r;
  logic [NSW-1:0]  ns_nx;
  logic [PW-1:0]   rem_r;
  logic [PW-1:0]   rem_nx;
  logic [PW-1:0]   trial;
  logic [QW-1:0]   quo_r;
  logic [QW-1:0]   quo_nx;
  logic [W-1:0]    d_r;
  logic            is_div_r;
  logic            start;

  assign start = (state != BUSY) && strobe_i && !kill_i;

  // One cycle of the recurrence. When W is not a multiple of the digit width the
  // operand is zero-padded at the MSB end, so the surplus digit positions are
  // consumed first and only ever produce zero quotient/root bits.
  always_comb begin
    rem_nx = rem_r;
    quo_nx = quo_r;
    ns_nx  = ns_r;
    trial  = '0;
    for (int i = 0; i < R; i++) begin
      if (is_div_r) begin
        rem_nx = {rem_nx[PW-2:0], ns_nx[NSW-1]};
        ns_nx  = ns_nx << 1;
        if (rem_nx >= PW'(d_r)) begin
          rem_nx = rem_nx - PW'(d_r);
          quo_nx = {quo_nx[QW-2:0], 1'b1};
        end else begin
          quo_nx = {quo_nx[QW-2:0], 1'b0};
        end
      end else begin
        rem_nx = {rem_nx[PW-3:0], ns_nx[NSW-1 -: 2]};
        ns_nx  = ns_nx << 2;
        trial  = PW'({quo_nx, 2'b01});
        if (rem_nx >= trial) begin
          rem_nx = rem_nx - trial;
          quo_nx = {quo_nx[QW-2:0], 1'b1};
        end else begin
          quo_nx = {quo_nx[QW-2:0], 1'b0};
        end
      end
    end
  end

  // Control: state, counter and registered result outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt_r   <= '0;
      ready_o <= 1'b1;
      done_o  <= 1'b0;
      Quo_o   <= '0;
      Rem_o   <= '0;
      dz_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= BUSY;
            ready_o <= 1'b0;
            cnt_r   <= is_div_i ? CW'(ITER_DIV - 1) : CW'(ITER_SQRT - 1);
          end else begin
            state   <= IDLE;
            ready_o <= 1'b1;
          end
        end
        BUSY: begin
          if (kill_i) begin
            state   <= IDLE;
            ready_o <= 1'b1;
          end else if (cnt_r == '0) begin
            state   <= DONE;
            ready_o <= 1'b1;
            done_o  <= 1'b1;
            Quo_o   <= quo_nx[W-1:0];
            Rem_o   <= rem_nx[W-1:0];
            dz_o    <= is_div_r && (d_r == '0);
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  // Datapath: operands latched on start, recurrence state advanced while busy
  always_ff @(posedge clk) begin
    if (start) begin
      rem_r    <= '0;
      quo_r    <= '0;
      d_r      <= D_i;
      is_div_r <= is_div_i;
      ns_r     <= is_div_i ? (NSW'(N_i) << (NSW - DIV_NW)) : (NSW'(N_i) << (NSW - SQ_NW));
    end else if (state == BUSY) begin
      rem_r <= rem_nx;
      quo_r <= quo_nx;
      ns_r  <= ns_nx;
    end
  end

endmodule
